riscv_csr_hpm: RTL and testbench
================================

Name: riscv_csr_hpm

Overview:
Parametrised counter/CSR block for the machine counter set: mcycle, minstret and NUM_HPM programmable hardware performance counters. It also owns the mcountinhibit, mcounteren and scounteren CSRs. It sits beside the CSR register file in the execute stage. Reads are registered at issue with a per-privilege access check; writes arrive from writeback. Unlike the existing CSR path, counters count dual-retire, are width-configurable, and flag overflow.

Parameters:
NUM_HPM, 4, number of mhpmcounter3..(3+NUM_HPM-1), range 0..29
COUNTER_W, 64, implemented counter width, range 33..64; bits above COUNTER_W read 0 and ignore writes

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
priv_i  input  2  current privilege (0=U, 1=S, 3=M)
csr_ren_i  input  1  issue-stage read strobe
csr_raddr_i  input  12  CSR read address
csr_rdata_o  output  32  registered read data
csr_hit_o  output  1  registered: address decoded by this block
csr_fault_o  output  1  registered: access denied (illegal instruction)
csr_write_i  input  1  writeback CSR write strobe
csr_waddr_i  input  12  writeback CSR address
csr_wdata_i  input  32  writeback CSR data
retire_i  input  2  instructions retired this cycle, 0..2
event_i  input  NUM_HPM  per-counter event pulse, bit k drives mhpmcounter(3+k)
ovf_o  output  32  sticky overflow flags, bit i = counter i (bit 1 always 0)

Behaviour:
- Reset (rst_ni low, async): all counters 0, mcountinhibit 0, mcounteren 0, scounteren 0, ovf flags 0; csr_rdata_o=0, csr_hit_o=0, csr_fault_o=0.
- Address map: mcycle 0xB00/0xB80 (high); minstret 0xB02/0xB82; mhpmcounter(3+k) 0xB03+k/0xB83+k; user read-only aliases 0xC00/0xC02/0xC03+k and high 0xC80/0xC82/0xC83+k; mcountinhibit 0x320; mcounteren 0x306; scounteren 0x106. Unimplemented hpm indices do not hit.
- Counting, per cycle, unless the inhibit bit is set: mcycle += 1; minstret += retire_i (0..2, zero-extended); hpm k += event_i[k].
- Wrap is modulo 2^COUNTER_W. A carry out of the top bit sets ovf_o[i] sticky. The flag clears only on a write to either half of that counter.
- minstret at all-ones with retire_i=2 wraps to 1 and sets the flag.
- Write priority: a writeback write to a counter half wins over the increment in the same cycle. The other half is held, and no increment is applied to that counter that cycle.
- The cycle after a low-half write of 0xFFFFFFFF, the counter resumes normal counting and the carry propagates into the high half.
- mcountinhibit writable bits: 0, 2, and 3..(3+NUM_HPM-1); bit 1 and the rest read 0.
- mcounteren and scounteren use the same writable mask.
- Writes to user aliases are ignored; the fault for those is raised at issue.
- Read (issue): when csr_ren_i=1, the result registers are loaded next edge with 1-cycle latency. When csr_ren_i=0, they load 0.
- csr_hit_o=1 for any mapped address.
- csr_fault_o=1 when a mapped address is accessed with insufficient privilege:
  - 0xBxx or 0x3xx with priv_i != 3;
  - 0x106 with priv_i == 0;
  - user alias index i with priv_i == 1 and mcounteren[i] == 0;
  - user alias index i with priv_i == 0 and (mcounteren[i] & scounteren[i]) == 0.
- On a fault, csr_rdata_o = 0.
- High-half reads return counter[COUNTER_W-1:32] zero-extended.
- Simultaneous read and write of the same CSR: the read returns the pre-write value (no bypass; the pipeline orders them).

Optional Feature:
HPM_EVENT_SEL_EN:
- When defined, adds mhpmevent(3+k) CSRs at 0x323+k (M-only, 5-bit writable, reset 0).
- Counter k then increments on event_bus_i[sel], where event_bus_i is a new 32-bit input port. Select value 0 means never count.
- event_i is unused in this configuration.
- When not defined, mhpmevent addresses do not hit, and counter k counts event_i[k] directly.

Test Plan:
- Reset, then 10 idle cycles, then read 0xB00 at M -> csr_rdata_o=10 (±pipeline offset of 1, fixed by the bench), csr_hit_o=1, csr_fault_o=0.
- retire_i=2 for 5 cycles, then read 0xB02 -> 10. Write 0xB02=0xFFFFFFFF and 0xB82=0xFFFFFFFF (COUNTER_W=64), then retire_i=2 once -> minstret=1 and ovf_o[2]=1. Then write 0xB02=0 -> ovf_o[2]=0.
- Write mcountinhibit=0x1, idle 20 cycles -> mcycle unchanged. Write 0 -> counting resumes on the next cycle.
- U-mode read of 0xC00 with mcounteren=1 and scounteren=0 -> csr_fault_o=1, rdata=0. Set scounteren=1 -> fault=0 and the value is returned. S-mode read of 0xB00 -> fault=1.
- Counter write and increment collision: event_i[0] held high while writing 0xB03=0x100 -> the cycle after, mhpmcounter3=0x100 and it increments thereafter. Read 0xB03+NUM_HPM -> csr_hit_o=0.
- COUNTER_W=40: write 0xB80=0xFFFFFFFF -> reading 0xB80 returns 0x000000FF. An increment past 2^40-1 wraps to 0 and sets the flag.

Source files
------------

// File: rtl/riscv_csr_hpm.sv
`default_nettype none
// ============================================================================
// riscv_csr_hpm : machine counters, inhibit and counter-enable CSRs.
// Optional macro HPM_EVENT_SEL_EN adds mhpmevent selectors.    Revision: 1.0
// ============================================================================
module riscv_csr_hpm #(
    parameter int NUM_HPM   = 4,
    parameter int COUNTER_W = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [1:0]         priv_i,
    input  logic               csr_ren_i,
    input  logic [11:0]        csr_raddr_i,
    output logic [31:0]        csr_rdata_o,
    output logic               csr_hit_o,
    output logic               csr_fault_o,
    input  logic               csr_write_i,
    input  logic [11:0]        csr_waddr_i,
    input  logic [31:0]        csr_wdata_i,
    input  logic [1:0]         retire_i,
    input  logic [NUM_HPM-1:0] event_i,
`ifdef HPM_EVENT_SEL_EN
    input  logic [31:0]        event_bus_i,
`endif
    output logic [31:0]        ovf_o
);
    localparam int          NC       = 3 + NUM_HPM;
    localparam logic [31:0] CNT_MASK = (((32'd1 << NUM_HPM) - 32'd1) << 3) | 32'd5;

    // Index 1 (the unused "time" slot) exists only to keep indices aligned with CSR numbers.
    logic [COUNTER_W-1:0] cnt [NC];
    logic [COUNTER_W:0]   sum [NC];
    logic [1:0]           inc [NC];
    logic                 wr_lo [NC];
    logic                 wr_hi [NC];
    logic [31:0]          ovf;
    logic [31:0]          inhibit;
    logic [31:0]          mcounteren;
    logic [31:0]          scounteren;
    logic [31:0]          rd_data;
    logic                 rd_hit;
    logic                 rd_fault;
    logic [63:0]          cval;

`ifdef HPM_EVENT_SEL_EN
    logic [4:0] evsel [NUM_HPM];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_HPM; k++) evsel[k] <= 5'd0;
        end else if (csr_write_i) begin
            for (int k = 0; k < NUM_HPM; k++) begin
                if (csr_waddr_i == 12'(12'h323 + k)) evsel[k] <= csr_wdata_i[4:0];
            end
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < NC; i++) inc[i] = 2'd0;
        inc[0] = 2'd1;
        inc[2] = retire_i;
        for (int k = 0; k < NUM_HPM; k++) begin
`ifdef HPM_EVENT_SEL_EN
            inc[3+k] = {1'b0, (evsel[k] != 5'd0) && event_bus_i[evsel[k]]};
`else
            inc[3+k] = {1'b0, event_i[k]};
`endif
        end
        for (int i = 0; i < NC; i++) begin
            sum[i]   = {1'b0, cnt[i]} + (COUNTER_W+1)'(inc[i]);
            wr_lo[i] = csr_write_i && (i != 1) && (csr_waddr_i == 12'(12'hB00 + i));
            wr_hi[i] = csr_write_i && (i != 1) && (csr_waddr_i == 12'(12'hB80 + i));
        end
    end

    // A write to either half pre-empts that counter's increment for the cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NC; i++) cnt[i] <= '0;
            ovf <= '0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (wr_lo[i] || wr_hi[i]) begin
                    if (wr_lo[i]) cnt[i][31:0] <= csr_wdata_i;
                    if (wr_hi[i]) cnt[i][COUNTER_W-1:32] <= csr_wdata_i[COUNTER_W-33:0];
                    ovf[i] <= 1'b0;
                end else if (!inhibit[i]) begin
                    cnt[i] <= sum[i][COUNTER_W-1:0];
                    if (sum[i][COUNTER_W]) ovf[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inhibit    <= '0;
            mcounteren <= '0;
            scounteren <= '0;
        end else if (csr_write_i) begin
            case (csr_waddr_i)
                12'h320: inhibit    <= csr_wdata_i & CNT_MASK;
                12'h306: mcounteren <= csr_wdata_i & CNT_MASK;
                12'h106: scounteren <= csr_wdata_i & CNT_MASK;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_hit   = 1'b0;
        rd_fault = 1'b0;
        rd_data  = '0;
        cval     = '0;
        for (int i = 0; i < NC; i++) begin
            if (i != 1) begin
                cval = 64'(cnt[i]);
                if (csr_raddr_i == 12'(12'hB00 + i) || csr_raddr_i == 12'(12'hB80 + i)) begin
                    rd_hit   = 1'b1;
                    rd_fault = (priv_i != 2'd3);
                    rd_data  = csr_raddr_i[7] ? cval[63:32] : cval[31:0];
                end
                if (csr_raddr_i == 12'(12'hC00 + i) || csr_raddr_i == 12'(12'hC80 + i)) begin
                    rd_hit   = 1'b1;
                    rd_fault = ((priv_i == 2'd1) && !mcounteren[i]) ||
                               ((priv_i == 2'd0) && !(mcounteren[i] && scounteren[i]));
                    rd_data  = csr_raddr_i[7] ? cval[63:32] : cval[31:0];
                end
            end
        end
        case (csr_raddr_i)
            12'h320: begin rd_hit = 1'b1; rd_fault = (priv_i != 2'd3); rd_data = inhibit;    end
            12'h306: begin rd_hit = 1'b1; rd_fault = (priv_i != 2'd3); rd_data = mcounteren; end
            12'h106: begin rd_hit = 1'b1; rd_fault = (priv_i == 2'd0); rd_data = scounteren; end
            default: ;
        endcase
`ifdef HPM_EVENT_SEL_EN
        for (int k = 0; k < NUM_HPM; k++) begin
            if (csr_raddr_i == 12'(12'h323 + k)) begin
                rd_hit   = 1'b1;
                rd_fault = (priv_i != 2'd3);
                rd_data  = {27'd0, evsel[k]};
            end
        end
`endif
        if (rd_fault) rd_data = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csr_rdata_o <= '0;
            csr_hit_o   <= 1'b0;
            csr_fault_o <= 1'b0;
        end else if (csr_ren_i) begin
            csr_rdata_o <= rd_data;
            csr_hit_o   <= rd_hit;
            csr_fault_o <= rd_fault;
        end else begin
            csr_rdata_o <= '0;
            csr_hit_o   <= 1'b0;
            csr_fault_o <= 1'b0;
        end
    end

    assign ovf_o = ovf;

endmodule
`default_nettype wire

// File: tb/tb_riscv_csr_hpm.sv
`default_nettype none
// tb_riscv_csr_hpm : directed and random stimulus on a 64-bit and a 40-bit
// instance, checked every cycle against an arithmetic model of the counter set.
module tb_riscv_csr_hpm;
    localparam int NH = 4;
    localparam int NC = 3 + NH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    priv = 2'd3;
    logic          ren = 1'b0;
    logic [11:0]   raddr = '0;
    logic          wr = 1'b0;
    logic [11:0]   waddr = '0;
    logic [31:0]   wdata = '0;
    logic [1:0]    retire = '0;
    logic [NH-1:0] ev = '0;

    logic [31:0] rdata0, rdata1, ovf0, ovf1;
    logic        hit0, hit1, fault0, fault1;

    riscv_csr_hpm #(.NUM_HPM(NH), .COUNTER_W(64)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .priv_i(priv), .csr_ren_i(ren), .csr_raddr_i(raddr),
        .csr_rdata_o(rdata0), .csr_hit_o(hit0), .csr_fault_o(fault0), .csr_write_i(wr),
        .csr_waddr_i(waddr), .csr_wdata_i(wdata), .retire_i(retire), .event_i(ev), .ovf_o(ovf0));

    riscv_csr_hpm #(.NUM_HPM(NH), .COUNTER_W(40)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .priv_i(priv), .csr_ren_i(ren), .csr_raddr_i(raddr),
        .csr_rdata_o(rdata1), .csr_hit_o(hit1), .csr_fault_o(fault1), .csr_write_i(wr),
        .csr_waddr_i(waddr), .csr_wdata_i(wdata), .retire_i(retire), .event_i(ev), .ovf_o(ovf1));

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    bit chk = 1'b0;

    // Model state: counter values are plain integers reduced modulo 2^W.
    longint unsigned wm [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_00FF_FFFF_FFFF};
    longint unsigned m_cnt [2][NC];
    bit              m_ovf [2][NC];
    logic [31:0]     m_inh, m_men, m_sen;
    logic [31:0]     exp_rd [2], pend_rd [2], exp_ovf [2], pend_ovf [2];
    logic            exp_hit [2], pend_hit [2], exp_fault [2], pend_fault [2];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            cmp("rdata64", rdata0, exp_rd[0]);
            cmp("hit64", {31'd0, hit0}, {31'd0, exp_hit[0]});
            cmp("fault64", {31'd0, fault0}, {31'd0, exp_fault[0]});
            cmp("ovf64", ovf0, exp_ovf[0]);
            cmp("rdata40", rdata1, exp_rd[1]);
            cmp("hit40", {31'd0, hit1}, {31'd0, exp_hit[1]});
            cmp("fault40", {31'd0, fault1}, {31'd0, exp_fault[1]});
            cmp("ovf40", ovf1, exp_ovf[1]);
        end
    end

    task automatic model_read(input int j, output logic [31:0] d, output logic h, output logic f);
        logic [3:0] grp;
        int         off;
        longint unsigned v;
        h = 1'b0; f = 1'b0; d = '0;
        if (!ren) return;
        grp = raddr[11:8];
        off = int'(raddr[6:0]);
        if ((grp == 4'hB || grp == 4'hC) && off < NC && off != 1) begin
            h = 1'b1;
            v = raddr[7] ? (m_cnt[j][off] >> 32) : (m_cnt[j][off] & 64'hFFFF_FFFF);
            d = v[31:0];
            if (grp == 4'hB) f = (priv != 2'd3);
            else f = (priv == 2'd1 && !m_men[off]) ||
                     (priv == 2'd0 && !(m_men[off] && m_sen[off]));
        end else if (raddr == 12'h320) begin h = 1'b1; d = m_inh; f = (priv != 2'd3);
        end else if (raddr == 12'h306) begin h = 1'b1; d = m_men; f = (priv != 2'd3);
        end else if (raddr == 12'h106) begin h = 1'b1; d = m_sen; f = (priv == 2'd0);
        end
        if (f) d = '0;
    endtask

    task automatic model_step();
        longint unsigned amt;
        bit lo, hi;
        for (int j = 0; j < 2; j++) model_read(j, pend_rd[j], pend_hit[j], pend_fault[j]);
        for (int j = 0; j < 2; j++) begin
            pend_ovf[j] = '0;
            for (int i = 0; i < NC; i++) begin
                if (i == 1) continue;
                lo = wr && waddr[11:8] == 4'hB && !waddr[7] && int'(waddr[6:0]) == i;
                hi = wr && waddr[11:8] == 4'hB &&  waddr[7] && int'(waddr[6:0]) == i;
                if (lo || hi) begin
                    if (lo) m_cnt[j][i] = (m_cnt[j][i] & 64'hFFFF_FFFF_0000_0000) | {32'd0, wdata};
                    if (hi) m_cnt[j][i] = ((m_cnt[j][i] & 64'hFFFF_FFFF) | ({32'd0, wdata} << 32)) & wm[j];
                    m_ovf[j][i] = 1'b0;
                end else if (!m_inh[i]) begin
                    amt = (i == 0) ? 64'd1 : (i == 2) ? {62'd0, retire} : {63'd0, ev[i-3]};
                    if (m_cnt[j][i] > wm[j] - amt) m_ovf[j][i] = 1'b1;
                    m_cnt[j][i] = (m_cnt[j][i] + amt) & wm[j];
                end
                pend_ovf[j][i] = m_ovf[j][i];
            end
        end
        if (wr) begin
            if (waddr == 12'h320) m_inh = wdata & 32'h7D;
            if (waddr == 12'h306) m_men = wdata & 32'h7D;
            if (waddr == 12'h106) m_sen = wdata & 32'h7D;
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NC; i++) begin m_cnt[j][i] = 0; m_ovf[j][i] = 1'b0; end
            pend_rd[j] = '0; pend_hit[j] = 1'b0; pend_fault[j] = 1'b0; pend_ovf[j] = '0;
        end
        m_inh = '0; m_men = '0; m_sen = '0;
    endtask

    task automatic cycle();
        if (rst_n) model_step(); else model_reset();
        @(posedge clk);
        for (int j = 0; j < 2; j++) begin
            exp_rd[j] = pend_rd[j]; exp_hit[j] = pend_hit[j];
            exp_fault[j] = pend_fault[j]; exp_ovf[j] = pend_ovf[j];
        end
        #1;
    endtask

    task automatic idle(input int n);
        ren = 1'b0; wr = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic rd(input logic [11:0] a, input logic [1:0] p);
        ren = 1'b1; raddr = a; priv = p; wr = 1'b0;
        cycle();
        ren = 1'b0;
    endtask

    task automatic wrt(input logic [11:0] a, input logic [31:0] d);
        wr = 1'b1; waddr = a; wdata = d; ren = 1'b0;
        cycle();
        wr = 1'b0;
    endtask

    function automatic logic [11:0] pick_addr();
        int r = int'($urandom_range(0, 15));
        logic [11:0] a;
        if (r <= 6)       a = 12'hB00 | 12'(($urandom_range(0, 1) << 7) | $urandom_range(0, 7));
        else if (r <= 10) a = 12'hC00 | 12'(($urandom_range(0, 1) << 7) | $urandom_range(0, 7));
        else if (r == 11) a = 12'h320;
        else if (r == 12) a = 12'h306;
        else if (r == 13) a = 12'h106;
        else if (r == 14) a = 12'(12'h323 + $urandom_range(0, 4));
        else              a = 12'($urandom);
        return a;
    endfunction

    function automatic logic [31:0] pick_data();
        int r = int'($urandom_range(0, 7));
        if (r < 2) return 32'hFFFF_FFFF;
        if (r == 2) return 32'hFFFF_FFFE - 32'($urandom_range(0, 3));
        if (r == 3) return 32'd0;
        return $urandom;
    endfunction

    initial begin
        logic [1:0] privs [3];
        privs[0] = 2'd0; privs[1] = 2'd1; privs[2] = 2'd3;
        for (int j = 0; j < 2; j++) begin
            exp_rd[j] = '0; exp_hit[j] = 1'b0; exp_fault[j] = 1'b0; exp_ovf[j] = '0;
        end
        model_reset();
        #2 rst_n = 1'b0;
        #1 chk = 1'b1;
        idle(3);
        rst_n = 1'b1;

        // Idle count then mcycle read
        idle(10);
        rd(12'hB00, 2'd3);
        cmp("lit_mcycle10", rdata0, 32'd10);
        cmp("lit_mcycle_hit", {31'd0, hit0}, 32'd1);
        cmp("lit_mcycle_fault", {31'd0, fault0}, 32'd0);

        // Dual retire and minstret wrap
        retire = 2'd2; idle(5); retire = 2'd0;
        rd(12'hB02, 2'd3);
        cmp("lit_minstret10", rdata0, 32'd10);
        wrt(12'hB02, 32'hFFFF_FFFF);
        wrt(12'hB82, 32'hFFFF_FFFF);
        retire = 2'd2; idle(1); retire = 2'd0;
        cmp("lit_ovf2_64", {31'd0, ovf0[2]}, 32'd1);
        cmp("lit_ovf2_40", {31'd0, ovf1[2]}, 32'd1);
        rd(12'hB02, 2'd3);
        cmp("lit_minstret_wrap", rdata0, 32'd1);
        wrt(12'hB02, 32'd0);
        cmp("lit_ovf2_clear", {31'd0, ovf0[2]}, 32'd0);

        // Inhibit freezes mcycle; counting resumes after clearing
        wrt(12'hB00, 32'h500);
        wrt(12'h320, 32'h1);
        idle(20);
        rd(12'hB00, 2'd3);
        cmp("lit_inhibit_hold", rdata0, 32'h501);
        wrt(12'h320, 32'h0);
        rd(12'hB00, 2'd3);
        rd(12'hB00, 2'd3);
        cmp("lit_inhibit_resume", rdata0, 32'h502);

        // Privilege checks on user aliases and M-only CSRs
        wrt(12'h306, 32'h1);
        rd(12'hC00, 2'd0);
        cmp("lit_u_fault", {31'd0, fault0}, 32'd1);
        cmp("lit_u_fault_data", rdata0, 32'd0);
        cmp("lit_u_fault_hit", {31'd0, hit0}, 32'd1);
        wrt(12'h106, 32'h1);
        rd(12'hC00, 2'd0);
        cmp("lit_u_ok", {31'd0, fault0}, 32'd0);
        rd(12'hB00, 2'd1);
        cmp("lit_s_mcycle_fault", {31'd0, fault0}, 32'd1);

        // Write/increment collision on mhpmcounter3
        ev = 4'b0001;
        wrt(12'hB03, 32'h100);
        rd(12'hB03, 2'd3);
        cmp("lit_hpm3_written", rdata0, 32'h100);
        rd(12'hB03, 2'd3);
        cmp("lit_hpm3_inc", rdata0, 32'h101);
        ev = '0;
        rd(12'(12'hB03 + NH), 2'd3);
        cmp("lit_unimpl_nohit", {31'd0, hit0}, 32'd0);

        // Width truncation, full wrap and low-to-high carry
        wrt(12'hB80, 32'hFFFF_FFFF);
        rd(12'hB80, 2'd3);
        cmp("lit_hi40", rdata1, 32'h0000_00FF);
        cmp("lit_hi64", rdata0, 32'hFFFF_FFFF);
        wrt(12'hB00, 32'hFFFF_FFFF);
        idle(1);
        cmp("lit_wrap_ovf64", {31'd0, ovf0[0]}, 32'd1);
        cmp("lit_wrap_ovf40", {31'd0, ovf1[0]}, 32'd1);
        rd(12'hB80, 2'd3);
        cmp("lit_wrap_hi40", rdata1, 32'd0);
        wrt(12'hB00, 32'hFFFF_FFFF);
        cmp("lit_ovf0_clear", {31'd0, ovf1[0]}, 32'd0);
        idle(1);
        rd(12'hB80, 2'd3);
        cmp("lit_carry_hi64", rdata0, 32'd1);
        cmp("lit_carry_hi40", rdata1, 32'd1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            priv   = privs[$urandom_range(0, 2)];
            ren    = ($urandom_range(0, 3) != 0);
            raddr  = pick_addr();
            wr     = ($urandom_range(0, 3) == 0);
            waddr  = pick_addr();
            wdata  = pick_data();
            if (waddr == 12'h320 && $urandom_range(0, 1) == 0) wdata = 32'd0;
            retire = 2'($urandom_range(0, 2));
            ev     = NH'($urandom);
            cycle();
        end
        ren = 1'b0; wr = 1'b0;
        idle(2);
        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
